sphere_pair_fetch: RTL and testbench
====================================

# sphere_pair_fetch

Job-level initiator that drives the dCollideSpheres collision kernel. It reads sphere-pair records from word-addressed memory and presents them as parallel operands. It starts the kernel by releasing its active-low reset, waits for `done`, and writes each contact result back to memory. It sits between the memory port and the kernel and processes `pair_count` pairs per job, one at a time.

## Interface
- `ADDR_W`, 10: memory address width, both read and write ports.
- `TIMEOUT`, 4096: maximum RUN cycles allowed per pair before it is abandoned.
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle request to begin a job; accepted only when `busy`=0.
- `pair_base`  in  ADDR_W  address of the first input record; latched on accept.
- `pair_count`  in  16  number of pairs in the job; latched on accept.
- `res_base`  in  ADDR_W  address of the first result record; latched on accept.
- `busy`  out  1  high from the cycle after accept until `job_done`.
- `job_done`  out  1  one-cycle pulse when the job completes.
- `hit_count`  out  16  number of pairs with `core_ret`=1; cleared on accept, held after the job.
- `mem_rd_en`  out  1  read strobe; memory returns `mem_rd_data` exactly 1 cycle later.
- `mem_rd_addr`  out  ADDR_W  read address.
- `mem_rd_data`  in  32  read data.
- `mem_wr_en`  out  1  write strobe.
- `mem_wr_addr`  out  ADDR_W  write address.
- `mem_wr_data`  out  32  write data.
- `core_x1`/`core_y1`/`core_z1`/`core_r1`  out  32 each  sphere 1 operands (IEEE-754 single).
- `core_x2`/`core_y2`/`core_z2`/`core_r2`  out  32 each  sphere 2 operands.
- `core_g1`/`core_g2`  out  32 each  geometry IDs, passed through unchanged.
- `core_rst_n`  out  1  kernel reset, active-low; low holds the kernel idle, high runs it.
- `core_done`  in  1  kernel done, a level signal.
- `core_ret`  in  1  kernel collision flag.
- `core_cx`/`core_cy`/`core_cz`/`core_nx`/`core_ny`/`core_nz`/`core_depth`  in  32 each  kernel contact outputs.

## Operation
- Input record for pair i: 10 words at `pair_base`+10·i+k, in order x1,y1,z1,r1,x2,y2,z2,r2,g1,g2 (k=0..9).
- Result record for pair i: 8 words at `res_base`+8·i+k, in order cx,cy,cz,nx,ny,nz,depth,flags.
  - flags = {30'b0, timeout, ret}.
- All address arithmetic is modulo 2^ADDR_W; it wraps silently.
- FSM states:
  - IDLE: on `start` with `pair_count`=0, go to DONE; on `start` with nonzero count, latch inputs, set i=0, clear `hit_count`, go to FETCH.
  - FETCH: issue 10 reads on consecutive cycles; capture each word into its operand register one cycle after its read. Lasts 11 cycles, then go to ARM.
  - ARM: `core_rst_n` low for 2 cycles, then go to RUN.
  - RUN: `core_rst_n` high; `core_done` is sampled only in this state.
    - On `core_done`=1: register all 7 contact words and `core_ret`; increment `hit_count` if ret=1; go to WRITE.
    - If `core_done` is not seen within TIMEOUT RUN cycles: contact words = 0, ret=0, timeout=1; go to WRITE.
  - WRITE: 8 writes on consecutive cycles, k=0..7, then go to NEXT.
  - NEXT: `core_rst_n` driven low; i++. If i==count, go to DONE; otherwise go to FETCH.
  - DONE: `job_done`=1 for one cycle, then go to IDLE.
- `start` while `busy`=1 is ignored. Latched job parameters do not change mid-job.
- Operand outputs hold their last fetched values and change only in FETCH.

## Timing
- Reset values: all outputs 0, including `core_rst_n`=0 (kernel held in reset); FSM in IDLE.
- `rst` mid-job: at the next edge all outputs return to reset values, the job is abandoned with no `job_done`, and any in-flight write is dropped. The next `start` works normally.
- `busy` rises the cycle after accept.
- Zero-count job: `job_done` pulses 2 cycles after `start` is sampled, with no memory traffic.
- Per-pair latency: 11 (FETCH) + 2 (ARM) + L + 8 (WRITE) + 1 (NEXT) = 22+L cycles.
  - L is the number of RUN cycles up to and including the one where `core_done` is sampled high; L is at most TIMEOUT.
- `mem_rd_en` and `mem_wr_en` are never high in the same cycle.
- At most one read and one write per cycle.

## Test plan
- Zero-count job: `start` with `pair_count`=0 -> `job_done` 2 cycles later; no `mem_rd_en` or `mem_wr_en`; `hit_count`=0; `core_rst_n` stays 0.
- One colliding pair: (0,0,0,r=0x3F800000) vs (0x3FC00000,0,0,r=0x3F800000); core model asserts done with ret=1 at L=30 -> reads at `pair_base`+0..9, operands match, 8 writes at `res_base`+0..7 carrying the model values with flags=0x1; `hit_count`=1; `job_done` 52 cycles after FETCH entry.
- Non-colliding pair: model returns ret=0 with zero outputs -> seven words written as 0, flags=0x0, `hit_count`=0.
- Address wrap: ADDR_W=10, 3 pairs, `res_base`=0x3F8, `pair_base`=0x3F0 -> result writes for pair 1 land at 0x000–0x007 and reads wrap correctly; `hit_count` equals the number of model ret=1 results.
- Timeout: TIMEOUT=64 and model never asserts done -> after 64 RUN cycles, zeros written with flags=0x2; `hit_count` unchanged; next pair proceeds.
- Reset mid-run: `rst` during RUN of pair 2 -> next edge all outputs 0, no further writes, no `job_done`; a fresh `start` completes correctly.

Source files
------------

// File: rtl/sphere_pair_fetch.sv
// sphere_pair_fetch: job-level initiator for the dCollideSpheres kernel.
// Fetches 10-word sphere-pair records, runs the kernel once per pair by
// releasing its reset, and writes the 8-word contact result back to memory.
//
// Handshake semantics:
//   start/busy  - start is a one-cycle request; it is taken only while busy=0
//                 and is ignored otherwise. busy rises the cycle after the
//                 accept and falls the cycle after the job_done pulse.
//   mem_rd_en   - one read per cycle; mem_rd_data is valid exactly one cycle
//                 after the strobe, with no back-pressure.
//   mem_wr_en   - one write per cycle, always accepted; never concurrent with
//                 a read.
//   core_done   - level from the kernel, sampled only while in RUN.
module sphere_pair_fetch #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pair_base,
  input  logic [15:0]       pair_count,
  input  logic [ADDR_W-1:0] res_base,
  output logic              busy,
  output logic              job_done,
  output logic [15:0]       hit_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic [31:0]       core_x1,
  output logic [31:0]       core_y1,
  output logic [31:0]       core_z1,
  output logic [31:0]       core_r1,
  output logic [31:0]       core_x2,
  output logic [31:0]       core_y2,
  output logic [31:0]       core_z2,
  output logic [31:0]       core_r2,
  output logic [31:0]       core_g1,
  output logic [31:0]       core_g2,
  output logic              core_rst_n,
  input  logic              core_done,
  input  logic              core_ret,
  input  logic [31:0]       core_cx,
  input  logic [31:0]       core_cy,
  input  logic [31:0]       core_cz,
  input  logic [31:0]       core_nx,
  input  logic [31:0]       core_ny,
  input  logic [31:0]       core_nz,
  input  logic [31:0]       core_depth,
  output logic [2:0]        dbg_state
);

  localparam int RC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_WRITE = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           state;
  logic [3:0]       step;       // cycle index within FETCH / ARM / WRITE
  logic [RC_W-1:0]  run_cnt;    // RUN cycles elapsed for the current pair
  logic [15:0]      pair_idx;
  logic [15:0]      count_q;
  logic [ADDR_W-1:0] rec_ptr;   // base of the current input record
  logic [ADDR_W-1:0] res_ptr;   // base of the current result record
  logic [9:0][31:0] ops;        // x1,y1,z1,r1,x2,y2,z2,r2,g1,g2
  logic [6:0][31:0] contact;    // cx,cy,cz,nx,ny,nz,depth
  logic             ret_q;
  logic             to_q;
  logic [31:0]      flags;

  assign flags     = {30'd0, to_q, ret_q};
  assign dbg_state = state;

  assign core_x1 = ops[0];
  assign core_y1 = ops[1];
  assign core_z1 = ops[2];
  assign core_r1 = ops[3];
  assign core_x2 = ops[4];
  assign core_y2 = ops[5];
  assign core_z2 = ops[6];
  assign core_r2 = ops[7];
  assign core_g1 = ops[8];
  assign core_g2 = ops[9];

  // Job sequencer: all outputs are registered and set on state entry so that
  // the first read/write of a phase lands on that phase's first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      step        <= '0;
      run_cnt     <= '0;
      pair_idx    <= '0;
      count_q     <= '0;
      rec_ptr     <= '0;
      res_ptr     <= '0;
      ops         <= '0;
      contact     <= '0;
      ret_q       <= 1'b0;
      to_q        <= 1'b0;
      busy        <= 1'b0;
      job_done    <= 1'b0;
      hit_count   <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      core_rst_n  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            hit_count <= '0;
            count_q   <= pair_count;
            rec_ptr   <= pair_base;
            res_ptr   <= res_base;
            pair_idx  <= '0;
            if (pair_count == 16'd0) begin
              state <= S_DONE;
            end else begin
              state       <= S_FETCH;
              step        <= '0;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= pair_base;
            end
          end
        end

        S_FETCH: begin
          // Word k was read at step k and is on mem_rd_data at step k+1.
          if (step != 4'd0) ops[step - 4'd1] <= mem_rd_data;
          if (step == 4'd9) mem_rd_en <= 1'b0;
          else if (step < 4'd9) mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
          if (step == 4'd10) begin
            state <= S_ARM;
            step  <= '0;
          end else begin
            step <= step + 4'd1;
          end
        end

        S_ARM: begin
          if (step == 4'd1) begin
            state      <= S_RUN;
            step       <= '0;
            run_cnt    <= '0;
            core_rst_n <= 1'b1;
          end else begin
            step <= step + 4'd1;
          end
        end

        S_RUN: begin
          if (core_done) begin
            contact     <= {core_depth, core_nz, core_ny, core_nx,
                            core_cz, core_cy, core_cx};
            ret_q       <= core_ret;
            to_q        <= 1'b0;
            if (core_ret) hit_count <= hit_count + 16'd1;
            state       <= S_WRITE;
            step        <= '0;
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= res_ptr;
            mem_wr_data <= core_cx;
          end else if (run_cnt == RC_W'(TIMEOUT - 1)) begin
            // Abandon the pair: zero contact, flag the timeout.
            contact     <= '0;
            ret_q       <= 1'b0;
            to_q        <= 1'b1;
            state       <= S_WRITE;
            step        <= '0;
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= res_ptr;
            mem_wr_data <= '0;
          end else begin
            run_cnt <= run_cnt + RC_W'(1);
          end
        end

        S_WRITE: begin
          if (step == 4'd7) begin
            mem_wr_en  <= 1'b0;
            core_rst_n <= 1'b0;
            state      <= S_NEXT;
            step       <= '0;
          end else begin
            step        <= step + 4'd1;
            mem_wr_addr <= mem_wr_addr + ADDR_W'(1);
            mem_wr_data <= (step == 4'd6) ? flags : contact[step[2:0] + 3'd1];
          end
        end

        S_NEXT: begin
          core_rst_n <= 1'b0;
          pair_idx   <= pair_idx + 16'd1;
          rec_ptr    <= rec_ptr + ADDR_W'(10);
          res_ptr    <= res_ptr + ADDR_W'(8);
          if (pair_idx + 16'd1 == count_q) begin
            state    <= S_DONE;
            job_done <= 1'b1;
          end else begin
            state       <= S_FETCH;
            step        <= '0;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= rec_ptr + ADDR_W'(10);
          end
        end

        S_DONE: begin
          // Arriving from NEXT the pulse is already up; a zero-count job
          // arrives with it low and raises it here first.
          if (job_done) begin
            job_done <= 1'b0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            job_done <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sphere_pair_fetch.sv
// Bench for sphere_pair_fetch: word memory model, a stub collision kernel
// driven from the operand pins, and a reference model that replays each job
// on its own copy of memory to predict reads, operands, writes and timing.
module tb_sphere_pair_fetch;

  localparam int AW = 10;
  localparam int TO = 64;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] pair_base;
  logic [15:0]   pair_count;
  logic [AW-1:0] res_base;
  logic          busy;
  logic          job_done;
  logic [15:0]   hit_count;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [31:0]   mem_rd_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [31:0]   mem_wr_data;
  logic [31:0]   core_x1, core_y1, core_z1, core_r1;
  logic [31:0]   core_x2, core_y2, core_z2, core_r2;
  logic [31:0]   core_g1, core_g2;
  logic          core_rst_n;
  logic          core_done;
  logic          core_ret;
  logic [31:0]   core_cx, core_cy, core_cz, core_nx, core_ny, core_nz, core_depth;
  logic [2:0]    dbg_state;

  sphere_pair_fetch #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .pair_base(pair_base),
    .pair_count(pair_count), .res_base(res_base), .busy(busy),
    .job_done(job_done), .hit_count(hit_count), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .core_x1(core_x1), .core_y1(core_y1), .core_z1(core_z1), .core_r1(core_r1),
    .core_x2(core_x2), .core_y2(core_y2), .core_z2(core_z2), .core_r2(core_r2),
    .core_g1(core_g1), .core_g2(core_g2), .core_rst_n(core_rst_n),
    .core_done(core_done), .core_ret(core_ret), .core_cx(core_cx),
    .core_cy(core_cy), .core_cz(core_cz), .core_nx(core_nx), .core_ny(core_ny),
    .core_nz(core_nz), .core_depth(core_depth), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  logic        mem_load;

  always @(posedge clk) begin
    if (mem_load) mem <= ref_mem;
    else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  // ---------------- stub kernel ----------------
  // ret = g1[0]; done after g2[4:0]+1 run cycles; never done if g2[31].
  function automatic logic [31:0] stub_word(input logic [9:0][31:0] o, input int j);
    case (j)
      0: return o[0] + o[4];
      1: return o[1] + o[5];
      2: return o[2] + o[6];
      3: return o[0] ^ o[4];
      4: return o[1] ^ o[5];
      5: return o[2] ^ o[6];
      default: return o[3] + o[7];
    endcase
  endfunction

  logic [9:0][31:0] pin_ops;
  logic [31:0]      run_cyc;
  assign pin_ops = {core_g2, core_g1, core_r2, core_z2, core_y2, core_x2,
                    core_r1, core_z1, core_y1, core_x1};

  always @(posedge clk) run_cyc <= core_rst_n ? run_cyc + 32'd1 : 32'd0;

  assign core_done  = core_rst_n && !pin_ops[9][31] && (run_cyc >= {27'd0, pin_ops[9][4:0]});
  assign core_ret   = pin_ops[8][0];
  assign core_cx    = core_ret ? stub_word(pin_ops, 0) : 32'd0;
  assign core_cy    = core_ret ? stub_word(pin_ops, 1) : 32'd0;
  assign core_cz    = core_ret ? stub_word(pin_ops, 2) : 32'd0;
  assign core_nx    = core_ret ? stub_word(pin_ops, 3) : 32'd0;
  assign core_ny    = core_ret ? stub_word(pin_ops, 4) : 32'd0;
  assign core_nz    = core_ret ? stub_word(pin_ops, 5) : 32'd0;
  assign core_depth = core_ret ? stub_word(pin_ops, 6) : 32'd0;

  // Expected result word j for a pair whose record is o.
  function automatic logic [31:0] ref_word(input logic [9:0][31:0] o, input int j);
    if (o[9][31]) return (j == 7) ? 32'd2 : 32'd0;
    if (j == 7) return {31'd0, o[8][0]};
    return o[8][0] ? stub_word(o, j) : 32'd0;
  endfunction

  // ---------------- scoreboard state ----------------
  int vectors;
  int miscompares;
  logic [AW+31:0]  wr_obs_q[$];
  logic [AW-1:0]   rd_obs_q[$];
  logic [319:0]    ops_obs_q[$];
  int both_cnt, rn_hi_cnt, jd_cnt;
  logic prev_rn;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: advance to the falling edge and record bus activity.
  task automatic tick();
    @(negedge clk);
    if (mem_wr_en) wr_obs_q.push_back({mem_wr_addr, mem_wr_data});
    if (mem_rd_en) rd_obs_q.push_back(mem_rd_addr);
    if (mem_rd_en && mem_wr_en) both_cnt++;
    if (core_rst_n) rn_hi_cnt++;
    if (core_rst_n && !prev_rn) ops_obs_q.push_back(pin_ops);
    prev_rn = core_rst_n;
    if (job_done) jd_cnt++;
  endtask

  task automatic load_mem();
    mem_load = 1'b1;
    tick();
    mem_load = 1'b0;
  endtask

  task automatic run_job(input logic [AW-1:0] pb, input int cnt,
                         input logic [AW-1:0] rb, input bit poke);
    logic [AW+31:0]   exp_q[$];
    logic [AW-1:0]    exp_rd_q[$];
    logic [319:0]     exp_op_q[$];
    logic [9:0][31:0] o;
    logic [AW-1:0]    a;
    logic [31:0]      w;
    logic [319:0]     ov, ev;
    int exp_cyc, exp_hits, cyc, lat, w0, r0, p0, j0, h0, n;

    exp_cyc  = (cnt == 0) ? 2 : 1;
    exp_hits = 0;
    for (int p = 0; p < cnt; p++) begin
      for (int k = 0; k < 10; k++) begin
        a = pb + AW'(10 * p + k);
        o[k] = ref_mem[a];
        exp_rd_q.push_back(a);
      end
      exp_op_q.push_back(o);
      lat = o[9][31] ? TO : int'(o[9][4:0]) + 1;
      exp_cyc += 22 + lat;
      if (!o[9][31] && o[8][0]) exp_hits++;
      for (int j = 0; j < 8; j++) begin
        a = rb + AW'(8 * p + j);
        w = ref_word(o, j);
        ref_mem[a] = w;
        exp_q.push_back({a, w});
      end
    end

    w0 = wr_obs_q.size(); r0 = rd_obs_q.size(); p0 = ops_obs_q.size();
    j0 = jd_cnt; h0 = rn_hi_cnt;
    check("busy_idle", {63'd0, busy}, 64'd0);
    pair_base = pb; pair_count = 16'(cnt); res_base = rb; start = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      start = 1'b0;
      if (cyc == 1) check("busy_rise", {63'd0, busy}, 64'd1);
      if (poke && cyc == 5) begin
        start = 1'b1; pair_base = ~pb; pair_count = 16'd7; res_base = ~rb;
      end
    end while (!job_done && cyc < exp_cyc + 64);

    check("jd_latency", 64'(cyc), 64'(exp_cyc));
    check("hit_count", {48'd0, hit_count}, 64'(exp_hits));

    check("rd_count", 64'(rd_obs_q.size() - r0), 64'(exp_rd_q.size()));
    n = exp_rd_q.size();
    if (rd_obs_q.size() - r0 < n) n = rd_obs_q.size() - r0;
    for (int i = 0; i < n; i++) check("rd_addr", 64'(rd_obs_q[r0 + i]), 64'(exp_rd_q[i]));

    check("wr_count", 64'(wr_obs_q.size() - w0), 64'(exp_q.size()));
    n = exp_q.size();
    if (wr_obs_q.size() - w0 < n) n = wr_obs_q.size() - w0;
    for (int i = 0; i < n; i++) check("wr_addr_data", 64'(wr_obs_q[w0 + i]), 64'(exp_q[i]));

    check("op_count", 64'(ops_obs_q.size() - p0), 64'(exp_op_q.size()));
    n = exp_op_q.size();
    if (ops_obs_q.size() - p0 < n) n = ops_obs_q.size() - p0;
    for (int i = 0; i < n; i++) begin
      ov = ops_obs_q[p0 + i];
      ev = exp_op_q[i];
      for (int k = 0; k < 10; k++) check("operand", 64'(ov[32*k +: 32]), 64'(ev[32*k +: 32]));
    end

    if (cnt == 0) check("kernel_held", 64'(rn_hi_cnt - h0), 64'd0);

    tick();
    check("jd_pulse", {63'd0, job_done}, 64'd0);
    check("busy_fall", {63'd0, busy}, 64'd0);
    check("jd_once", 64'(jd_cnt - j0), 64'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int w1, r1, j1, p1, cyc;
    logic [31:0] rec [10];

    vectors = 0; miscompares = 0;
    both_cnt = 0; rn_hi_cnt = 0; jd_cnt = 0; prev_rn = 1'b0;
    rst = 1'b1; start = 1'b0; pair_base = '0; pair_count = '0; res_base = '0;
    mem_load = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
    load_mem();
    repeat (3) tick();

    // reset values
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_job_done", {63'd0, job_done}, 64'd0);
    check("rst_hit_count", {48'd0, hit_count}, 64'd0);
    check("rst_rd_en", {63'd0, mem_rd_en}, 64'd0);
    check("rst_wr_en", {63'd0, mem_wr_en}, 64'd0);
    check("rst_core_rst_n", {63'd0, core_rst_n}, 64'd0);
    check("rst_core_x1", {32'd0, core_x1}, 64'd0);
    check("rst_wr_data", {32'd0, mem_wr_data}, 64'd0);
    rst = 1'b0;
    tick();

    // zero-count job
    run_job(AW'($urandom_range(0, 1023)), 0, AW'($urandom_range(0, 1023)), 1'b0);

    // one colliding pair, done at L=30
    rec = '{32'h0, 32'h0, 32'h0, 32'h3F800000, 32'h3FC00000, 32'h0, 32'h0,
            32'h3F800000, 32'd1, 32'd29};
    for (int k = 0; k < 10; k++) ref_mem[10'h100 + k] = rec[k];
    load_mem();
    run_job(10'h100, 1, 10'h200, 1'b0);

    // non-colliding pair
    rec = '{32'h40000000, 32'h0, 32'h0, 32'h3F800000, 32'hC0000000, 32'h0,
            32'h0, 32'h3F000000, 32'd0, 32'd11};
    for (int k = 0; k < 10; k++) ref_mem[10'h140 + k] = rec[k];
    load_mem();
    run_job(10'h140, 1, 10'h240, 1'b0);

    // address wrap: 3 pairs straddling the top of memory
    run_job(10'h3F0, 3, 10'h3F8, 1'b0);

    // timeout on pair 0, normal hit on pair 1
    for (int k = 0; k < 8; k++) ref_mem[10'h050 + k] = $urandom;
    ref_mem[10'h058] = 32'd1; ref_mem[10'h059] = 32'h8000_0000;
    for (int k = 0; k < 8; k++) ref_mem[10'h05A + k] = $urandom;
    ref_mem[10'h062] = 32'd1; ref_mem[10'h063] = 32'd5;
    load_mem();
    run_job(10'h050, 2, 10'h080, 1'b0);

    // randomized jobs, one with a start pulse while busy
    for (int t = 0; t < 6; t++)
      run_job(AW'($urandom_range(0, 1023)), $urandom_range(1, 4),
              AW'($urandom_range(0, 1023)), t == 2);

    // reset during RUN of the second pair
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 10; k++) ref_mem[10'h180 + 10 * p + k] = $urandom;
    ref_mem[10'h189] = 32'd4;
    ref_mem[10'h193] = 32'd19;
    ref_mem[10'h19D] = 32'd2;
    load_mem();
    p1 = ops_obs_q.size();
    pair_base = 10'h180; pair_count = 16'd3; res_base = 10'h300; start = 1'b1;
    cyc = 0;
    do begin
      tick();
      start = 1'b0;
      cyc++;
    end while (ops_obs_q.size() - p1 < 2 && cyc < 500);
    check("reach_run2", 64'(ops_obs_q.size() - p1), 64'd2);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("mid_busy", {63'd0, busy}, 64'd0);
    check("mid_job_done", {63'd0, job_done}, 64'd0);
    check("mid_hit_count", {48'd0, hit_count}, 64'd0);
    check("mid_rd_en", {63'd0, mem_rd_en}, 64'd0);
    check("mid_wr_en", {63'd0, mem_wr_en}, 64'd0);
    check("mid_rd_addr", 64'(mem_rd_addr), 64'd0);
    check("mid_wr_addr", 64'(mem_wr_addr), 64'd0);
    check("mid_wr_data", {32'd0, mem_wr_data}, 64'd0);
    check("mid_core_rst_n", {63'd0, core_rst_n}, 64'd0);
    check("mid_core_x1", {32'd0, core_x1}, 64'd0);
    check("mid_core_g2", {32'd0, core_g2}, 64'd0);
    rst = 1'b0;
    w1 = wr_obs_q.size(); r1 = rd_obs_q.size(); j1 = jd_cnt;
    repeat (150) tick();
    check("post_rst_writes", 64'(wr_obs_q.size() - w1), 64'd0);
    check("post_rst_reads", 64'(rd_obs_q.size() - r1), 64'd0);
    check("post_rst_job_done", 64'(jd_cnt - j1), 64'd0);
    ref_mem = mem;
    run_job(10'h180, 3, 10'h300, 1'b0);

    check("rd_wr_overlap", 64'(both_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
